// File: rtl/level_seq_pkg.sv
// Shared encodings for the level sequencer: FSM state type and key-flag indices.
package level_seq_pkg;

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    PLAY  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam int KEY_NEXT0 = 0;
  localparam int KEY_NEXT1 = 4;
  localparam int KEY_PREV0 = 2;
  localparam int KEY_PREV1 = 6;
  localparam int KEY_SEL   = 8;
  localparam int KEY_BACK  = 9;

endpackage

// File: rtl/level_sequencer_if.sv
// Bundle between the level sequencer and its neighbours: key decoder flags,
// per-level completion / pixel addresses in, level control and selected address out.
interface level_sequencer_if #(
  parameter int NUM_LEVELS = 5,
  parameter int ADDR_W     = 17,
  parameter int KEY_W      = 10
);
  localparam int LVL_W = $clog2(NUM_LEVELS + 1);

  logic [KEY_W-1:0]             key_down;
  logic [NUM_LEVELS-1:0]        level_clear;
  logic [ADDR_W-1:0]            menu_addr;
  logic [NUM_LEVELS*ADDR_W-1:0] level_addr;
  logic [ADDR_W-1:0]            pixel_addr;
  logic [NUM_LEVELS-1:0]        level_en;
  logic                         level_rst;
  logic [LVL_W-1:0]             cur_level;
  logic [1:0]                   fsm_state;

  // Surrounding system: supplies keys, clears and addresses, observes the sequencer.
  modport master (
    output key_down, level_clear, menu_addr, level_addr,
    input  pixel_addr, level_en, level_rst, cur_level, fsm_state
  );

  // The sequencer itself.
  modport slave (
    input  key_down, level_clear, menu_addr, level_addr,
    output pixel_addr, level_en, level_rst, cur_level, fsm_state
  );
endinterface

// File: rtl/level_sequencer_key_event.sv
// Key event generator: turns level-held key flags into single-cycle action
// pulses. An action fires only on the first nonzero cycle after an all-zero
// cycle; next > prev > select > back, and unmapped keys consume the event.
module key_event
  import level_seq_pkg::*;
#(
  parameter int KEY_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_down_i,
  output logic             ev_next_o,
  output logic             ev_prev_o,
  output logic             ev_sel_o,
  output logic             ev_back_o
);

  localparam logic [KEY_W-1:0] USED_MASK =
    (KEY_W'(1) << KEY_NEXT0) | (KEY_W'(1) << KEY_NEXT1) |
    (KEY_W'(1) << KEY_PREV0) | (KEY_W'(1) << KEY_PREV1) |
    (KEY_W'(1) << KEY_SEL)   | (KEY_W'(1) << KEY_BACK);

  logic arm_q, arm_d;
  logic any_key, fire;
  logic unused_keys;

  assign any_key     = |key_down_i;
  assign fire        = arm_q & any_key;
  // Unmapped keys still count toward any_key; only their identity is unused.
  assign unused_keys = ^(key_down_i & ~USED_MASK);

  // Arm flag: rearmed by an idle cycle, dropped by any pressed cycle (held keys never refire).
  always_comb begin
    arm_d = ~any_key;
  end

  // Priority encode the firing event into one action pulse.
  always_comb begin
    ev_next_o = 1'b0;
    ev_prev_o = 1'b0;
    ev_sel_o  = 1'b0;
    ev_back_o = 1'b0;
    if (fire) begin
      if (key_down_i[KEY_NEXT0] || key_down_i[KEY_NEXT1]) begin
        ev_next_o = 1'b1;
      end else if (key_down_i[KEY_PREV0] || key_down_i[KEY_PREV1]) begin
        ev_prev_o = 1'b1;
      end else if (key_down_i[KEY_SEL]) begin
        ev_sel_o = 1'b1;
      end else if (key_down_i[KEY_BACK]) begin
        ev_back_o = 1'b1;
      end
    end
  end

  // Arm flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q <= 1'b1;
    end else begin
      arm_q <= arm_d;
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// level_sequencer: game-flow controller. Menu cursor selects a level, the
// chosen level is enabled and reset on entry, completion freezes it for
// CLEAR_HOLD cycles before advancing, and the campaign ends in DONE.
// Optional build macro LEVEL_LOCK_EN: menu cursor limited to the highest
// level reached so far (unlocked register, cleared only by rst).
//
// state | meaning
// MENU  | cursor navigation, menu renderer on screen
// PLAY  | selected level enabled and on screen
// CLEAR | level completed, frozen on screen for CLEAR_HOLD cycles
// DONE  | campaign finished, menu renderer on screen
module level_sequencer
  import level_seq_pkg::*;
#(
  parameter int NUM_LEVELS = 5,
  parameter int ADDR_W     = 17,
  parameter int KEY_W      = 10,
  parameter int CLEAR_HOLD = 50_000_000
) (
  input  logic           clk,
  input  logic           rst,
  level_sequencer_if.slave bus
);

  localparam int LVL_W = $clog2(NUM_LEVELS + 1);
  localparam int CNT_W = $clog2(CLEAR_HOLD + 1);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_LAST  = LVL_W'(NUM_LEVELS);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CLEAR_HOLD - 1);

  seq_state_e             state_q, state_d;
  logic [LVL_W-1:0]       cur_q, cur_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_rst_q, level_rst_d;
  logic [LVL_W-1:0]       limit;
  logic [LVL_W-1:0]       lvl_idx;
  logic [NUM_LEVELS-1:0]  lvl_onehot;
  logic                   clear_hit;
  logic [ADDR_W-1:0]      lvl_pix;
  logic                   ev_next, ev_prev, ev_sel, ev_back;

`ifdef LEVEL_LOCK_EN
  logic [LVL_W-1:0]       unlocked_q, unlocked_d;
  assign limit = unlocked_q;
`else
  assign limit = LVL_LAST;
`endif

  key_event #(.KEY_W(KEY_W)) u_key_event (
    .clk        (clk),
    .rst        (rst),
    .key_down_i (bus.key_down),
    .ev_next_o  (ev_next),
    .ev_prev_o  (ev_prev),
    .ev_sel_o   (ev_sel),
    .ev_back_o  (ev_back)
  );

  assign lvl_idx    = cur_q - LVL_ONE;
  assign lvl_onehot = NUM_LEVELS'(1) << lvl_idx;
  // Clear flags of levels other than the active one are masked off here.
  assign clear_hit  = |(bus.level_clear & lvl_onehot);

  // Pick the active level's pixel address slice.
  always_comb begin
    lvl_pix = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (lvl_idx == LVL_W'(i)) begin
        lvl_pix = bus.level_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Next-state, cursor, hold counter and level reset pulse.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
`ifdef LEVEL_LOCK_EN
    unlocked_d = unlocked_q;
`endif
    unique case (state_q)
      MENU: begin
        if (ev_next) begin
          if (cur_q < limit) cur_d = cur_q + LVL_ONE;
        end else if (ev_prev) begin
          if (cur_q > LVL_ONE) cur_d = cur_q - LVL_ONE;
        end else if (ev_sel) begin
          state_d = PLAY;
        end
      end
      PLAY: begin
        // Completion outranks a simultaneous back request.
        if (clear_hit) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (ev_back) begin
          state_d = MENU;
        end
      end
      CLEAR: begin
        if (cnt_q == HOLD_LAST) begin
          if (cur_q < LVL_LAST) begin
            state_d = PLAY;
            cur_d   = cur_q + LVL_ONE;
`ifdef LEVEL_LOCK_EN
            if (cur_d > unlocked_q) unlocked_d = cur_d;
`endif
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (ev_sel || ev_back) begin
          state_d = MENU;
          cur_d   = LVL_ONE;
        end
      end
      default: state_d = MENU;
    endcase
    level_rst_d = (state_d == PLAY) && (state_q != PLAY);
  end

  // State, cursor, counter and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MENU;
      cur_q       <= LVL_ONE;
      cnt_q       <= '0;
      level_rst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      level_rst_q <= level_rst_d;
    end
  end

`ifdef LEVEL_LOCK_EN
  // Highest level reached; survives returns to the menu.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unlocked_q <= LVL_ONE;
    end else begin
      unlocked_q <= unlocked_d;
    end
  end
`endif

  assign bus.fsm_state  = state_q;
  assign bus.cur_level  = cur_q;
  assign bus.level_rst  = level_rst_q;
  assign bus.level_en   = (state_q == PLAY) ? lvl_onehot : '0;
  assign bus.pixel_addr = (state_q == PLAY || state_q == CLEAR) ? lvl_pix : bus.menu_addr;

endmodule

// File: doc/level_sequencer.md
# level_sequencer

Parametrised game-flow controller between the PS2 key decoder, the per-level game modules and the VGA pixel path. A menu cursor picks one of NUM_LEVELS levels. The block enables and resets the chosen level, detects level completion, advances through the campaign, and returns to the menu. It also muxes the active module's pixel address onto the frame-buffer read port, in place of the fixed five-map switch.

## Interface
- NUM_LEVELS, 5: number of level modules (1..15).
- ADDR_W, 17: pixel address width.
- KEY_W, 10: width of key_down vector.
- CLEAR_HOLD, 50_000_000: cycles the cleared level stays frozen on screen before advancing (≥1).
- Derived: LVL_W = $clog2(NUM_LEVELS+1).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- key_down  in  KEY_W  level-held key flags. [0]/[4] next, [2]/[6] prev, [8] select, [9] back.
- level_clear  in  NUM_LEVELS  bit i high = level i+1 completed (level).
- menu_addr  in  ADDR_W  menu renderer address.
- level_addr  in  NUM_LEVELS*ADDR_W  level i+1 address at bits [i*ADDR_W +: ADDR_W].
- pixel_addr  out  ADDR_W  selected address, combinational from registered state.
- level_en  out  NUM_LEVELS  one-hot enable of the playing level, else 0.
- level_rst  out  1  one-cycle pulse on every entry to PLAY.
- cur_level  out  LVL_W  cursor / active level, 1..NUM_LEVELS.
- fsm_state  out  2  MENU=0, PLAY=1, CLEAR=2, DONE=3.

## Operation
- Key press event: an action fires only on the first cycle key_down is nonzero after a cycle in which it was all-zero (arm flag). The arm flag is rearmed when key_down==0. Holding keys never repeats.
- Priority within one event: next > prev > select > back. Unmapped keys consume the event with no action.
- MENU: next increments cur_level, saturating at the limit; prev decrements, saturating at 1; select → PLAY. pixel_addr=menu_addr.
- PLAY: level_en = 1<<(cur_level-1), pixel_addr = level_addr slice of cur_level.
  - level_clear[cur_level-1] → CLEAR.
  - back → MENU.
  - level_clear bits of other levels are ignored.
  - A clear and a back in the same cycle: clear wins.
- CLEAR: level_en=0, pixel_addr holds the current level's slice, and the hold counter counts CLEAR_HOLD cycles.
  - Then, if cur_level<NUM_LEVELS: cur_level+1 → PLAY (level_rst pulse).
  - Else → DONE.
  - Keys are ignored; the arm flag still tracks.
- DONE: pixel_addr=menu_addr. Back or select → MENU with cur_level=1.
- Reset values: fsm_state=MENU, cur_level=1, level_en=0, level_rst=0, counter=0, arm=1, unlocked=1. pixel_addr=menu_addr.

## Timing
- State and cursor update on the clock edge after the qualifying key cycle.
- level_en and the pixel_addr switch are visible in the same cycle as the new state.
- level_rst is high exactly in the first PLAY cycle.
- CLEAR lasts exactly CLEAR_HOLD cycles. The counter is width $clog2(CLEAR_HOLD+1) and clears on entry.
- Asynchronous rst mid-PLAY or mid-CLEAR returns everything to reset values immediately. No level_rst pulse is issued.

## Configuration
- LEVEL_LOCK_EN defined:
  - An unlocked register (LVL_W bits, reset 1) records the highest level reached.
  - The MENU next action saturates at unlocked instead of NUM_LEVELS.
  - CLEAR→PLAY of level k raises unlocked to max(unlocked,k).
  - unlocked survives returns to MENU; only rst clears it.
- LEVEL_LOCK_EN undefined: no unlocked register. All levels are selectable; the saturation limit is NUM_LEVELS.

## Structure
- Package level_seq_pkg holds:
  - the state encodings MENU/PLAY/CLEAR/DONE as a typedef;
  - the key index constants KEY_NEXT0=0, KEY_NEXT1=4, KEY_PREV0=2, KEY_PREV1=6, KEY_SEL=8, KEY_BACK=9.
- One sub-module: key_event. It holds the arm flag plus the priority encoder, and outputs one-cycle pulses ev_next, ev_prev, ev_sel and ev_back.
- The FSM, hold counter and address mux stay in level_sequencer.

## Test plan
- Navigation, default parameters:
  - Reset, then pulse next ×6 with releases between → cur_level=5, saturated.
  - Then prev ×5 → cur_level=1.
  - Holding next for 100 cycles → exactly one increment.
- Start a level: cursor 3, select → fsm_state=PLAY, level_en=5'b00100, level_rst for one cycle, pixel_addr=level_addr slice 2.
- Clear handling, CLEAR_HOLD=4:
  - In level 3, assert level_clear[1] → no change.
  - Assert level_clear[2] → CLEAR for exactly 4 cycles with level_en=0.
  - Then PLAY at level 4 with a level_rst pulse.
- Campaign end and same-cycle events:
  - Clear in level 5 → DONE, pixel_addr=menu_addr; select → MENU, cur_level=1.
  - level_clear and back in the same cycle → CLEAR.
- LEVEL_LOCK_EN: after reset, next ×3 → cur_level stays 1. After clearing level 1, back to MENU: next → 2, next → stays 2.
- Asynchronous rst asserted mid-CLEAR → outputs return to reset values before the next edge, with no level_rst pulse.
